regfile_bank: RTL
=================

Name: regfile_bank

Overview:
- Storage stage of the 8-entry register file. Holds eight WIDTH-bit registers A..H and drives them in parallel to the downstream 8:1 read multiplexer (regAout..regHout).
- Provides one write port with a valid/ready handshake.
- Provides a sequential bulk-clear engine that walks all eight entries, plus per-entry dirty flags.

Parameters:
- WIDTH, 8, data width of each register and of every regXout port.
- RESET_VALUE, 0, value loaded into every register by reset and by bulk clear; WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- wr_valid  input  1  write request
- wr_ready  output  1  write port can accept; write fires when wr_valid && wr_ready at a rising edge
- wr_addr  input  3  target register: 0=A, 1=B, ..., 7=H
- wr_data  input  WIDTH  write data
- clr_req  input  1  bulk-clear request, sampled at rising edge
- busy  output  1  clear engine active
- dirty  output  8  bit i set = register i written since last reset or clear
- regAout..regHout  output  WIDTH each  current register contents; eight separate ports

Behaviour:
- Reset (rst_n=0):
  - Asynchronous, acts immediately, no clock needed.
  - All registers = RESET_VALUE, dirty=8'h00, state=IDLE, clear pointer=0, busy=0, wr_ready=1.
  - Held while rst_n=0; normal operation starts at the first rising edge after deassertion.
- State machine, two states, state held in a register:
  - IDLE: wr_ready=1, busy=0.
  - CLEAR: wr_ready=0, busy=1.
  - wr_ready and busy decode from the state register only; no combinational path from any input.
- Write, in IDLE:
  - On a rising edge with wr_valid=1, reg[wr_addr]<=wr_data and dirty[wr_addr]<=1.
  - New value appears on the matching regXout one cycle after the accepting edge; no write-through or bypass.
  - Back-to-back writes accepted every cycle.
  - A repeated write to the same address overwrites; the last write wins.
- Outputs: regXout are direct register outputs with no logic after the flops; the read mux provides the zero-latency read path.
- Clear entry:
  - In IDLE, clr_req=1 at an edge moves the state to CLEAR with pointer=0.
  - If wr_valid=1 on that same edge, the write is also performed. The clear then overwrites that register later, so its final value is RESET_VALUE and its dirty bit is 0.
- CLEAR operation:
  - Each cycle, reg[pointer]<=RESET_VALUE, dirty[pointer]<=0, pointer++.
  - The edge that clears entry 7 returns the state to IDLE and pointer to 0.
  - Exactly 8 cycles with busy=1.
  - Entries not yet reached keep their old values; a partial clear is visible on regXout.
- In CLEAR:
  - wr_valid is ignored; the upstream source must hold the request until wr_ready=1.
  - clr_req is ignored; it is not queued.
- Pointer: 3 bits, wraps 7->0.
- Reset mid-clear: abort immediately, all state goes to reset values.
- X on wr_addr while a write is accepted is illegal; the bench flags it as an error.

Test Plan:
- Reset → all regXout=8'h00, dirty=8'h00, wr_ready=1, busy=0, with no clock edge applied.
- Write 3'd2/8'hA5 then 3'd7/8'h3C on consecutive cycles → regCout=8'hA5 one cycle after the first edge, regHout=8'h3C one cycle after the second, dirty=8'h84, other outputs 8'h00.
- Write every register with 8'h11*(i+1), then pulse clr_req → busy=1 and wr_ready=0 for exactly 8 cycles. regAout clears first and regHout last, one register per cycle; afterwards all outputs=8'h00 and dirty=8'h00.
- Same edge: wr_valid=1, addr 3'd0, data 8'hFF, plus clr_req=1 → regAout=8'hFF for exactly one cycle, then 8'h00; dirty[0] ends at 0.
- During CLEAR, hold wr_valid=1 (addr 3'd5, data 8'h5A) and pulse clr_req again → no write while busy. Write is accepted on the first IDLE edge and regFout=8'h5A the cycle after; no second clear occurs.
- Assert rst_n=0 at clear cycle 3 after loading 8'h77 everywhere → all outputs=8'h00, busy=0 immediately. After release, a write to 3'd4 of 8'h42 works normally.

Source files
------------

// File: rtl/regfile_bank.sv
// Storage stage of the 8-entry register file.
// It has one handshaked write port, a sequential bulk-clear engine and per-entry dirty flags.
module regfile_bank #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_req,
  output logic             busy,
  output logic [7:0]       dirty,
  output logic [WIDTH-1:0] regAout,
  output logic [WIDTH-1:0] regBout,
  output logic [WIDTH-1:0] regCout,
  output logic [WIDTH-1:0] regDout,
  output logic [WIDTH-1:0] regEout,
  output logic [WIDTH-1:0] regFout,
  output logic [WIDTH-1:0] regGout,
  output logic [WIDTH-1:0] regHout
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [2:0]       clrPtr;
  logic [WIDTH-1:0] regs [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register array is reset like any other flop because RESET_VALUE is architecturally visible.
      for (int i = 0; i < 8; i++) regs[i] <= RESET_VALUE;
      dirty    <= 8'h00;
      state    <= IDLE;
      clrPtr   <= 3'd0;
      busy     <= 1'b0;
      wr_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (wr_valid && wr_ready) begin
            regs[wr_addr]  <= wr_data;
            dirty[wr_addr] <= 1'b1;
          end
          // A write on the same edge still lands; the walk overwrites it later.
          if (clr_req) begin
            state    <= CLEAR;
            clrPtr   <= 3'd0;
            busy     <= 1'b1;
            wr_ready <= 1'b0;
          end
        end
        CLEAR: begin
          regs[clrPtr]  <= RESET_VALUE;
          dirty[clrPtr] <= 1'b0;
          clrPtr        <= clrPtr + 3'd1;
          if (clrPtr == 3'd7) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign regAout = regs[0];
  assign regBout = regs[1];
  assign regCout = regs[2];
  assign regDout = regs[3];
  assign regEout = regs[4];
  assign regFout = regs[5];
  assign regGout = regs[6];
  assign regHout = regs[7];

endmodule
